mdu_hilo: RTL and testbench
===========================

// Module: mdu_hilo
// PURPOSE
//  Multi-cycle multiply/divide unit with HI/LO registers, sitting in EX beside the single-cycle ALU.
//  Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the EX stage and writes HI/LO after a fixed latency.
//  Drives busy so hazard logic stalls MFHI/MFLO and later MD ops while an operation is in flight.
//  req, the exception/interrupt flag from CP0, blocks issue of a new operation.
// PARAMETERS
//  MULT_LAT  5   cycles busy is high for MULT/MULTU (>=1)
//  DIV_LAT   10  cycles busy is high for DIV/DIVU (>=1)
// PORTS
//  clk      in   1   clock, rising edge
//  reset_n  in   1   asynchronous, active-low reset
//  start    in   1   issue md_op this cycle
//  md_op    in   4   0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7-10 see MDU_MADD_EN
//  A1       in   32  rs operand (dividend / multiplicand / mthi-mtlo source)
//  A2       in   32  rt operand (divisor / multiplier)
//  req      in   1   exception/interrupt pending; suppresses issue
//  busy     out  1   operation in flight
//  hi       out  32  HI register value
//  lo       out  32  LO register value
// BEHAVIOUR
//  - Reset (reset_n=0, asynchronous): busy=0, hi=0, lo=0, counter=0, pending result discarded.
//    Reset mid-operation aborts it; HI/LO do not receive the pending result.
//  - Accept: at a rising edge with start=1, req=0, busy=0 and md_op valid.
//    Ignored with no effect if busy=1, req=1 or md_op invalid.
//  - mthi/mtlo: on accept, hi<=A1 (or lo<=A1) at that edge; busy stays 0; visible the next cycle.
//  - mult/multu/div/divu: on accept, the 64-bit result is latched into pending regs and counter<=LAT.
//    busy = (counter!=0); counter decrements each cycle.
//    At the edge where counter goes 1->0, {hi,lo}<=pending.
//    So busy is high for exactly LAT cycles; new HI/LO are visible in the first cycle busy=0.
//  - mult: {hi,lo}=$signed(A1)*$signed(A2). multu: unsigned 32x32->64.
//  - div: lo=quotient, hi=remainder, truncating toward zero; remainder takes the sign of the dividend.
//    divu: unsigned.
//  - Signed 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0; no trap.
//  - Divisor 0 (div or divu): the op runs the full DIV_LAT with busy high; hi/lo unchanged at completion.
//  - States: IDLE (counter==0) -> RUN on accepted mult/div. RUN -> IDLE when counter reaches 0.
//    mthi/mtlo do not leave IDLE.
//  - start while in RUN (including the final RUN cycle) is ignored. Upstream holds the instruction
//    via stall = busy | (start & md_op in 1..4,7..10).
//  - req is sampled only at accept; an in-flight operation completes regardless of req.
//  - Operands are captured at accept; A1/A2 changes during RUN have no effect.
// CONFIGURATION
//  - MDU_MADD_EN defined: md_op 7 madd, 8 maddu, 9 msub, 10 msubu are valid.
//    Latency MULT_LAT; completion writes {hi,lo} <= {hi,lo} +/- product.
//    Signed or unsigned product as named; 64-bit wrap, no overflow flag.
//    The accumulate reads {hi,lo} at completion, not at accept.
//  - MDU_MADD_EN undefined: md_op 7-15 are invalid and ignored; no accumulate adder is synthesised.
// TESTING
//  1. mult A1=0xFFFFFFFE, A2=3 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
//     multu same operands -> hi=0x00000002, lo=0xFFFFFFFA.
//  2. div A1=-7 (0xFFFFFFF9), A2=2 -> busy 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//     divu 7/0 -> busy 10 cycles; hi/lo unchanged.
//  3. mthi A1=0x12345678 -> hi=0x12345678 next cycle, busy never asserted.
//     mtlo while busy -> ignored; lo gets only the mult result.
//  4. start=1, req=1, mult 2*3 -> busy stays 0; hi/lo unchanged.
//     Second start during RUN -> ignored, counter not reloaded.
//  5. mult 2*3, reset_n=0 at cycle 3 of RUN -> busy=0, hi=lo=0 immediately and still after reset_n=1.
//  6. MDU_MADD_EN defined: hi=0, lo=0xFFFFFFFF, madd 1*1 -> hi=1, lo=0.
//     msubu from hi=0, lo=0 with 1*1 -> hi=lo=0xFFFFFFFF.

Source files
------------

// File: rtl/mdu_hilo.sv
// mdu_hilo: multi-cycle multiply/divide unit owning the HI/LO registers.
//
// Sits in EX beside the single-cycle ALU. It accepts MULT/MULTU/DIV/DIVU
// and MTHI/MTLO. Multiply and divide results land in HI/LO after a fixed
// latency. While an operation is in flight, busy lets hazard logic stall
// MFHI/MFLO and any later MD ops.
//
// Ports:
//   clk      in   1   clock, rising edge
//   reset_n  in   1   asynchronous active-low reset
//   start    in   1   issue md_op this cycle
//   md_op    in   4   0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo,
//                     7 madd, 8 maddu, 9 msub, 10 msubu (accumulate build only)
//   A1       in   32  rs operand (dividend / multiplicand / mthi-mtlo source)
//   A2       in   32  rt operand (divisor / multiplier)
//   req      in   1   exception/interrupt pending; blocks issue
//   busy     out  1   operation in flight
//   hi, lo   out  32  HI / LO register values
//
// Build option: define MDU_MADD_EN to add madd/maddu/msub/msubu. These
// ops accumulate into {hi,lo} at completion. When MDU_MADD_EN is not
// defined, opcodes 7-15 are ignored and no accumulate adder is built.
module mdu_hilo #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] A1,
  input  logic [31:0] A2,
  input  logic        req,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAXL = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CW   = $clog2(MAXL + 1);
  localparam logic [CW-1:0] MLAT = CW'(MULT_LAT);
  localparam logic [CW-1:0] DLAT = CW'(DIV_LAT);

  typedef enum logic {IDLE, RUN} state_e;
`ifdef MDU_MADD_EN
  typedef enum logic [1:0] {ACC_NONE, ACC_ADD, ACC_SUB} acc_e;
`endif

  state_e         state_q;
  logic [CW-1:0]  cnt_q;
  logic [31:0]    hi_q, lo_q;
  logic [63:0]    pend_q;
  logic           pwr_q;      // pending result must be written at completion
`ifdef MDU_MADD_EN
  acc_e           acc_q;
  acc_e           acc_d;
`endif

  // ---------------- decode ----------------
  logic op_valid, is_mul, is_div, is_sgn, is_mthi, is_mtlo;

  always_comb begin
    op_valid = 1'b0;
    is_mul   = 1'b0;
    is_div   = 1'b0;
    is_sgn   = 1'b0;
    is_mthi  = 1'b0;
    is_mtlo  = 1'b0;
`ifdef MDU_MADD_EN
    acc_d    = ACC_NONE;
`endif
    case (md_op)
      4'd1: begin op_valid = 1'b1; is_mul = 1'b1; is_sgn = 1'b1; end
      4'd2: begin op_valid = 1'b1; is_mul = 1'b1; end
      4'd3: begin op_valid = 1'b1; is_div = 1'b1; is_sgn = 1'b1; end
      4'd4: begin op_valid = 1'b1; is_div = 1'b1; end
      4'd5: begin op_valid = 1'b1; is_mthi = 1'b1; end
      4'd6: begin op_valid = 1'b1; is_mtlo = 1'b1; end
`ifdef MDU_MADD_EN
      4'd7:  begin op_valid = 1'b1; is_mul = 1'b1; is_sgn = 1'b1; acc_d = ACC_ADD; end
      4'd8:  begin op_valid = 1'b1; is_mul = 1'b1;                acc_d = ACC_ADD; end
      4'd9:  begin op_valid = 1'b1; is_mul = 1'b1; is_sgn = 1'b1; acc_d = ACC_SUB; end
      4'd10: begin op_valid = 1'b1; is_mul = 1'b1;                acc_d = ACC_SUB; end
`endif
      default: ;
    endcase
  end

  // ---------------- datapath ----------------
  logic signed [63:0] sprod;
  logic        [63:0] uprod;
  assign sprod = $signed({{32{A1[31]}}, A1}) * $signed({{32{A2[31]}}, A2});
  assign uprod = {32'd0, A1} * {32'd0, A2};

  // Divisor is forced to 1 for divide-by-zero, where the result is
  // discarded anyway, and for MIN/-1, where MIN/1 gives exactly the
  // architectural answer (q=MIN, r=0). This also keeps the simulator
  // from trapping.
  logic               div_zero, div_ovf;
  logic signed [31:0] sdvs, sq, sr;
  logic        [31:0] udvs, uq, ur;
  assign div_zero = (A2 == 32'd0);
  assign div_ovf  = (A1 == 32'h8000_0000) && (A2 == 32'hFFFF_FFFF);
  assign sdvs     = (div_zero || div_ovf) ? 32'sd1 : $signed(A2);
  assign udvs     = div_zero ? 32'd1 : A2;
  assign sq       = $signed(A1) / sdvs;
  assign sr       = $signed(A1) % sdvs;
  assign uq       = A1 / udvs;
  assign ur       = A1 % udvs;

  logic [63:0] res_d;
  always_comb begin
    if (is_div) res_d = is_sgn ? {sr, sq} : {ur, uq};
    else        res_d = is_sgn ? sprod : uprod;
  end

  // Accumulate uses HI/LO as they are at completion, not at accept.
  logic [63:0] done_val;
`ifdef MDU_MADD_EN
  always_comb begin
    case (acc_q)
      ACC_ADD: done_val = {hi_q, lo_q} + pend_q;
      ACC_SUB: done_val = {hi_q, lo_q} - pend_q;
      default: done_val = pend_q;
    endcase
  end
`else
  assign done_val = pend_q;
`endif

  logic accept;
  assign accept = start && !req && (state_q == IDLE) && op_valid;

  // ---------------- state ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      pend_q  <= '0;
      pwr_q   <= 1'b0;
`ifdef MDU_MADD_EN
      acc_q   <= ACC_NONE;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (is_mthi) hi_q <= A1;
            if (is_mtlo) lo_q <= A1;
            if (is_mul || is_div) begin
              pend_q  <= res_d;
              pwr_q   <= !(is_div && div_zero);
              cnt_q   <= is_div ? DLAT : MLAT;
              state_q <= RUN;
`ifdef MDU_MADD_EN
              acc_q   <= acc_d;
`endif
            end
          end
        end
        RUN: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == {{(CW-1){1'b0}}, 1'b1}) begin
            state_q <= IDLE;
            if (pwr_q) {hi_q, lo_q} <= done_val;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = (cnt_q != '0);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Directed self-checking bench for mdu_hilo (default latencies 5 / 10).
module tb_mdu_hilo;

  localparam logic [3:0] OP_NONE = 4'd0, OP_MULT = 4'd1, OP_MULTU = 4'd2,
                         OP_DIV  = 4'd3, OP_DIVU = 4'd4, OP_MTHI  = 4'd5,
                         OP_MTLO = 4'd6, OP_MADD = 4'd7, OP_MADDU = 4'd8,
                         OP_MSUB = 4'd9, OP_MSUBU = 4'd10;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  md_op = 4'd0;
  logic [31:0] A1 = 32'd0;
  logic [31:0] A2 = 32'd0;
  logic        req = 1'b0;
  logic        busy;
  logic [31:0] hi, lo;

  int nvec = 0;
  int nerr = 0;

  mdu_hilo #(.MULT_LAT(5), .DIV_LAT(10)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .md_op(md_op),
    .A1(A1), .A2(A2), .req(req), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Drive an op for one cycle; returns at the negedge after the accept edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; md_op = op; A1 = a; A2 = b;
    @(negedge clk);
    start = 1'b0; md_op = OP_NONE;
  endtask

  // Counts negedges with busy high (bounded).
  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 60) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    nvec++; if (busy !== 1'b0)    begin nerr++; $display("FAIL reset_busy got %h want 0", busy); end
    nvec++; if (hi !== 32'd0)     begin nerr++; $display("FAIL reset_hi got %h want 0", hi); end
    nvec++; if (lo !== 32'd0)     begin nerr++; $display("FAIL reset_lo got %h want 0", lo); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mult;
    int n;
    issue(OP_MULT, 32'hFFFF_FFFE, 32'd3);
    wait_idle(n);
    nvec++; if (n != 5) begin nerr++; $display("FAIL mult_busy_cycles got %0d want 5", n); end
    nvec++; if (hi !== 32'hFFFF_FFFF) begin nerr++; $display("FAIL mult_hi got %h want ffffffff", hi); end
    nvec++; if (lo !== 32'hFFFF_FFFA) begin nerr++; $display("FAIL mult_lo got %h want fffffffa", lo); end
    issue(OP_MULTU, 32'hFFFF_FFFE, 32'd3);
    wait_idle(n);
    nvec++; if (n != 5) begin nerr++; $display("FAIL multu_busy_cycles got %0d want 5", n); end
    nvec++; if (hi !== 32'h0000_0002) begin nerr++; $display("FAIL multu_hi got %h want 00000002", hi); end
    nvec++; if (lo !== 32'hFFFF_FFFA) begin nerr++; $display("FAIL multu_lo got %h want fffffffa", lo); end
  endtask

  task automatic test_div;
    int n;
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    nvec++; if (n != 10) begin nerr++; $display("FAIL div_busy_cycles got %0d want 10", n); end
    nvec++; if (lo !== 32'hFFFF_FFFD) begin nerr++; $display("FAIL div_lo got %h want fffffffd", lo); end
    nvec++; if (hi !== 32'hFFFF_FFFF) begin nerr++; $display("FAIL div_hi got %h want ffffffff", hi); end
    issue(OP_DIVU, 32'd7, 32'd0);
    wait_idle(n);
    nvec++; if (n != 10) begin nerr++; $display("FAIL divu0_busy_cycles got %0d want 10", n); end
    nvec++; if (hi !== 32'hFFFF_FFFF) begin nerr++; $display("FAIL divu0_hi got %h want ffffffff", hi); end
    nvec++; if (lo !== 32'hFFFF_FFFD) begin nerr++; $display("FAIL divu0_lo got %h want fffffffd", lo); end
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    nvec++; if (lo !== 32'h8000_0000) begin nerr++; $display("FAIL div_ovf_lo got %h want 80000000", lo); end
    nvec++; if (hi !== 32'h0000_0000) begin nerr++; $display("FAIL div_ovf_hi got %h want 00000000", hi); end
    issue(OP_DIVU, 32'd100, 32'd7);
    wait_idle(n);
    nvec++; if (lo !== 32'd14) begin nerr++; $display("FAIL divu_lo got %h want 0000000e", lo); end
    nvec++; if (hi !== 32'd2)  begin nerr++; $display("FAIL divu_hi got %h want 00000002", hi); end
  endtask

  task automatic test_mthi_mtlo;
    int n;
    issue(OP_MTHI, 32'h1234_5678, 32'd0);
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL mthi_busy got %h want 0", busy); end
    nvec++; if (hi !== 32'h1234_5678) begin nerr++; $display("FAIL mthi_hi got %h want 12345678", hi); end
    issue(OP_MTLO, 32'h0BAD_F00D, 32'd0);
    nvec++; if (lo !== 32'h0BAD_F00D) begin nerr++; $display("FAIL mtlo_lo got %h want 0badf00d", lo); end
    // mtlo while a mult is running must be dropped
    issue(OP_MULT, 32'd2, 32'd3);
    start = 1'b1; md_op = OP_MTLO; A1 = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0; md_op = OP_NONE;
    wait_idle(n);
    nvec++; if (n != 4) begin nerr++; $display("FAIL mtlo_busy_rest got %0d want 4", n); end
    nvec++; if (lo !== 32'd6) begin nerr++; $display("FAIL mtlo_busy_lo got %h want 00000006", lo); end
    nvec++; if (hi !== 32'd0) begin nerr++; $display("FAIL mtlo_busy_hi got %h want 00000000", hi); end
  endtask

  task automatic test_req;
    req = 1'b1;
    issue(OP_MULT, 32'd7, 32'd7);
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL req_busy got %h want 0", busy); end
    issue(OP_MTHI, 32'hFFFF_0000, 32'd0);
    repeat (6) @(negedge clk);
    nvec++; if (hi !== 32'd0) begin nerr++; $display("FAIL req_hi got %h want 00000000", hi); end
    nvec++; if (lo !== 32'd6) begin nerr++; $display("FAIL req_lo got %h want 00000006", lo); end
    req = 1'b0;
  endtask

  task automatic test_back_to_back;
    int n;
    issue(OP_MULT, 32'd3, 32'd5);
    A1 = 32'hFFFF_FFFF; A2 = 32'h7777_7777;  // operands already captured
    @(negedge clk);
    start = 1'b1; md_op = OP_DIV; A1 = 32'd100; A2 = 32'd7;
    @(negedge clk);
    start = 1'b0; md_op = OP_NONE;
    wait_idle(n);
    nvec++; if (n != 3) begin nerr++; $display("FAIL b2b_busy_rest got %0d want 3", n); end
    nvec++; if (lo !== 32'd15) begin nerr++; $display("FAIL b2b_lo got %h want 0000000f", lo); end
    nvec++; if (hi !== 32'd0)  begin nerr++; $display("FAIL b2b_hi got %h want 00000000", hi); end
    // start in the final RUN cycle is dropped too
    issue(OP_MULTU, 32'd4, 32'd4);
    repeat (4) @(negedge clk);
    nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL last_run_busy got %h want 1", busy); end
    start = 1'b1; md_op = OP_MTHI; A1 = 32'hAAAA_5555;
    @(negedge clk);
    start = 1'b0; md_op = OP_NONE;
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL last_run_done got %h want 0", busy); end
    nvec++; if (hi !== 32'd0)  begin nerr++; $display("FAIL last_run_hi got %h want 00000000", hi); end
    nvec++; if (lo !== 32'd16) begin nerr++; $display("FAIL last_run_lo got %h want 00000010", lo); end
  endtask

  task automatic test_invalid;
    issue(OP_NONE, 32'h1111_1111, 32'd2);
    issue(4'd11, 32'h2222_2222, 32'd2);
    issue(4'd15, 32'h3333_3333, 32'd2);
`ifndef MDU_MADD_EN
    issue(OP_MADD, 32'h4444_4444, 32'd2);
`endif
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL inv_busy got %h want 0", busy); end
    repeat (6) @(negedge clk);
    nvec++; if (hi !== 32'd0)  begin nerr++; $display("FAIL inv_hi got %h want 00000000", hi); end
    nvec++; if (lo !== 32'd16) begin nerr++; $display("FAIL inv_lo got %h want 00000010", lo); end
  endtask

`ifdef MDU_MADD_EN
  task automatic test_madd;
    int n;
    issue(OP_MTHI, 32'd0, 32'd0);
    issue(OP_MTLO, 32'hFFFF_FFFF, 32'd0);
    issue(OP_MADD, 32'd1, 32'd1);
    wait_idle(n);
    nvec++; if (n != 5) begin nerr++; $display("FAIL madd_busy got %0d want 5", n); end
    nvec++; if (hi !== 32'd1) begin nerr++; $display("FAIL madd_hi got %h want 00000001", hi); end
    nvec++; if (lo !== 32'd0) begin nerr++; $display("FAIL madd_lo got %h want 00000000", lo); end
    issue(OP_MTHI, 32'd0, 32'd0);
    issue(OP_MTLO, 32'd0, 32'd0);
    issue(OP_MSUBU, 32'd1, 32'd1);
    wait_idle(n);
    nvec++; if (hi !== 32'hFFFF_FFFF) begin nerr++; $display("FAIL msubu_hi got %h want ffffffff", hi); end
    nvec++; if (lo !== 32'hFFFF_FFFF) begin nerr++; $display("FAIL msubu_lo got %h want ffffffff", lo); end
    issue(OP_MTHI, 32'd0, 32'd0);
    issue(OP_MTLO, 32'd5, 32'd0);
    issue(OP_MSUB, 32'd2, 32'd3);
    wait_idle(n);
    nvec++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFF) begin nerr++; $display("FAIL msub got %h want ffffffffffffffff", {hi, lo}); end
    issue(OP_MADDU, 32'hFFFF_FFFF, 32'd2);
    wait_idle(n);
    nvec++; if ({hi, lo} !== 64'h0000_0001_FFFF_FFFD) begin nerr++; $display("FAIL maddu got %h want 00000001fffffffd", {hi, lo}); end
  endtask
`endif

  task automatic test_reset_mid_run;
    int n;
    issue(OP_MULT, 32'd2, 32'd3);
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL rst_run_busy got %h want 0", busy); end
    nvec++; if ({hi, lo} !== 64'd0) begin nerr++; $display("FAIL rst_run_hilo got %h want 0", {hi, lo}); end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    wait_idle(n);
    nvec++; if (n != 0) begin nerr++; $display("FAIL rst_after_busy got %0d want 0", n); end
    nvec++; if ({hi, lo} !== 64'd0) begin nerr++; $display("FAIL rst_after_hilo got %h want 0", {hi, lo}); end
  endtask

  initial begin
    test_reset;
    test_mult;
    test_div;
    test_mthi_mtlo;
    test_req;
    test_back_to_back;
    test_invalid;
`ifdef MDU_MADD_EN
    test_madd;
`endif
    test_reset_mid_run;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
